// File: rtl/shift_loader.sv
// shift_loader: upstream feeder for a LINE_LEN-stage nibble shift line.
//
// Accepts nibbles over a valid/ready handshake into a small FIFO. Each accepted
// nibble causes exactly one shift of the downstream line. The block tracks how
// many live nibbles the line holds. A flush first drains any buffered nibbles
// into the line, then shifts LINE_LEN zeros so the line ends empty without a
// reset.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   upstream nibble present on in_data
//   in_data    nibble to load
//   in_ready   block accepts a nibble this cycle
//   flush      single-cycle request to zero the line
//   hold       downstream freeze; no shift while high
//   shn        shift enable to the line
//   si         serial-in nibble to the line; 0 whenever shn=0
//   fill_cnt   live nibbles in the line, saturating at LINE_LEN
//   line_full  fill_cnt == LINE_LEN
//   busy       FSM not idle
module shift_loader #(
    parameter int unsigned DW       = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LINE_LEN = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          flush,
    input  logic          hold,
    output logic          shn,
    output logic [DW-1:0] si,
    output logic [3:0]    fill_cnt,
    output logic          line_full,
    output logic          busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned ZW = $clog2(LINE_LEN);

    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [3:0]    LineLen = 4'(LINE_LEN);
    localparam logic [ZW-1:0] ZLast   = ZW'(LINE_LEN - 1);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StZero} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [ZW-1:0]   zcnt_q, zcnt_d;
    logic [3:0]      fill_q, fill_d;
    logic            push, pop;

    // Handshake and shift decode use registered state only (plus hold).
    always_comb begin
        in_ready = (count_q < DepthC) && ((state_q == StIdle) || (state_q == StFeed));
        shn      = 1'b0;
        si       = '0;
        unique case (state_q)
            StFeed, StDrain: begin
                shn = !hold && (count_q != '0);
                si  = shn ? mem_q[rd_ptr_q] : '0;
            end
            StZero: begin
                shn = !hold;
            end
            default: ;
        endcase
    end

    assign push = in_valid && in_ready;
    assign pop  = shn && ((state_q == StFeed) || (state_q == StDrain));

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    end

    // Next-state: decisions look at the post-edge FIFO count so a nibble pushed
    // while idle is presented to the line in the very next cycle.
    always_comb begin
        state_d = state_q;
        zcnt_d  = zcnt_q;
        fill_d  = fill_q;
        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    state_d = (count_d != '0) ? StDrain : StZero;
                end else if (count_d != '0) begin
                    state_d = StFeed;
                end
            end
            StFeed: begin
                if (flush) begin
                    state_d = (count_d != '0) ? StDrain : StZero;
                end else if (count_d == '0) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (count_d == '0) begin
                    state_d = StZero;
                end
            end
            StZero: begin
                if (shn) begin
                    if (zcnt_q == ZLast) begin
                        state_d = StIdle;
                        zcnt_d  = '0;
                        fill_d  = '0;
                    end else begin
                        zcnt_d = zcnt_q + ZW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop && (fill_q != LineLen)) begin
            fill_d = fill_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            zcnt_q   <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            zcnt_q   <= zcnt_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign fill_cnt  = fill_q;
    assign line_full = (fill_q == LineLen);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_loader.sv
// Directed self-checking bench for shift_loader.
module tb_shift_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       flush;
    logic       hold;
    logic       shn;
    logic [3:0] si;
    logic [3:0] fill_cnt;
    logic       line_full;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    shift_loader #(
        .DW(4),
        .DEPTH(4),
        .LINE_LEN(9)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .flush(flush),
        .hold(hold),
        .shn(shn),
        .si(si),
        .fill_cnt(fill_cnt),
        .line_full(line_full),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge, drive inputs, settle, then checks may follow.
    task automatic cyc(input logic v, input logic [3:0] d, input logic f, input logic h);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        flush    = f;
        hold     = h;
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_shn"}, 32'(shn), 32'd0);
        chk({tag, "_si"}, 32'(si), 32'd0);
        chk({tag, "_fill"}, 32'(fill_cnt), 32'd0);
        chk({tag, "_full"}, 32'(line_full), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        flush    = 1'b0;
        hold     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_vals("reset");
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        flush    = 1'b0;
        hold     = 1'b0;

        // Reset values
        do_reset();

        // Single-word latency
        cyc(1'b1, 4'hA, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("lat_shn", 32'(shn), 32'd1);
        chk("lat_si", 32'(si), 32'hA);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("lat_shn_after", 32'(shn), 32'd0);
        chk("lat_si_after", 32'(si), 32'd0);
        chk("lat_fill", 32'(fill_cnt), 32'd1);

        // Streaming 1..11 and fill saturation
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            cyc(i <= 11, 4'(i), 1'b0, 1'b0);
            if (i >= 2) begin
                int ef;
                ef = (i - 2 > 9) ? 9 : i - 2;
                chk($sformatf("stream_shn_%0d", i - 1), 32'(shn), 32'd1);
                chk($sformatf("stream_si_%0d", i - 1), 32'(si), 32'(i - 1));
                chk($sformatf("stream_fill_%0d", i - 1), 32'(fill_cnt), 32'(ef));
                chk($sformatf("stream_full_%0d", i - 1), 32'(line_full), 32'(ef == 9));
            end
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("stream_end_shn", 32'(shn), 32'd0);
        chk("stream_end_fill", 32'(fill_cnt), 32'd9);
        chk("stream_end_full", 32'(line_full), 32'd1);

        // Backpressure with hold
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 4'(i), 1'b0, 1'b1);
            chk($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'(i <= 4));
            chk($sformatf("bp_shn_%0d", i), 32'(shn), 32'd0);
        end
        // Full FIFO: offered word 7 is refused even though hold drops now.
        cyc(1'b1, 4'h7, 1'b0, 1'b0);
        chk("bp_ready_drop", 32'(in_ready), 32'd0);
        chk("bp_shn_1", 32'(shn), 32'd1);
        chk("bp_si_1", 32'(si), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            cyc(1'b0, 4'h0, 1'b0, 1'b0);
            chk($sformatf("bp_shn_%0d", i), 32'(shn), 32'd1);
            chk($sformatf("bp_si_%0d", i), 32'(si), 32'(i));
            chk($sformatf("bp_ready_after_%0d", i), 32'(in_ready), 32'd1);
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("bp_no_extra_shn", 32'(shn), 32'd0);
        chk("bp_ready_end", 32'(in_ready), 32'd1);
        chk("bp_fill_end", 32'(fill_cnt), 32'd4);

        // Flush with pending data
        do_reset();
        cyc(1'b1, 4'h5, 1'b0, 1'b1);
        cyc(1'b1, 4'h6, 1'b0, 1'b1);
        cyc(1'b1, 4'h7, 1'b1, 1'b0);
        chk("fl_ready_accept", 32'(in_ready), 32'd1);
        chk("fl_shn_d0", 32'(shn), 32'd1);
        chk("fl_si_d0", 32'(si), 32'h5);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("fl_si_d1", 32'(si), 32'h6);
        chk("fl_ready_drain", 32'(in_ready), 32'd0);
        chk("fl_busy_drain", 32'(busy), 32'd1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("fl_shn_d2", 32'(shn), 32'd1);
        chk("fl_si_d2", 32'(si), 32'h7);
        // Nine zero shifts with one hold cycle inserted after the fourth.
        for (int j = 0; j < 10; j++) begin
            cyc(1'b0, 4'h0, 1'b0, j == 4);
            chk($sformatf("fl_zshn_%0d", j), 32'(shn), 32'(j != 4));
            chk($sformatf("fl_zsi_%0d", j), 32'(si), 32'd0);
            chk($sformatf("fl_zbusy_%0d", j), 32'(busy), 32'd1);
            chk($sformatf("fl_zready_%0d", j), 32'(in_ready), 32'd0);
            chk($sformatf("fl_zfill_%0d", j), 32'(fill_cnt), 32'd3);
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("fl_end_busy", 32'(busy), 32'd0);
        chk("fl_end_fill", 32'(fill_cnt), 32'd0);
        chk("fl_end_shn", 32'(shn), 32'd0);
        chk("fl_end_ready", 32'(in_ready), 32'd1);

        // Reset during the 4th zero shift
        do_reset();
        cyc(1'b1, 4'h8, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("rm_si_data", 32'(si), 32'h8);
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 4'h0, 1'b0, 1'b0);
            chk($sformatf("rm_zshn_%0d", j), 32'(shn), 32'd1);
        end
        rst_n = 1'b0;
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_reset_vals("rm");
        for (int j = 0; j < 6; j++) begin
            cyc(1'b0, 4'h0, 1'b0, 1'b0);
            chk($sformatf("rm_quiet_%0d", j), 32'(shn), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
